fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter NOP_INSTR, default 32'h0000_0013, is the instruction word placed in IF/ID on a bubble or flush.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 pc  in  `INSTR_WIDTH  current fetch address from the PC register.
REQ-006 pc_en  out  1  PC load enable: PC takes next_pc at the next edge.
REQ-007 imem_req  out  1  instruction memory request.
REQ-008 imem_addr  out  `INSTR_WIDTH  request address.
REQ-009 imem_ack  in  1  memory completion; may be asserted in the same cycle as imem_req.
REQ-010 imem_rdata  in  `INSTR_WIDTH  instruction word, valid when imem_ack=1.
REQ-011 id_stall  in  1  decode cannot accept; IF/ID holds.
REQ-012 flush  in  1  redirect; the upstream next_pc mux selects the target while flush=1.
REQ-013 if_id_pc, if_id_instr  out  `INSTR_WIDTH each  IF/ID register contents.
REQ-014 if_id_valid  out  1  IF/ID holds a live instruction.

Function
REQ-015 The FSM states shall be BOOT, REQ, HOLD and DRAIN.
REQ-016 BOOT: pc_en=1 and imem_req=0, so PC advances from 32'hFFFF_FFFC to 0; the next state is REQ.
REQ-017 REQ: imem_req=1 and imem_addr=pc; pc_en=0 until imem_ack; the request is held with a stable address until ack.
REQ-018 REQ, ack, !id_stall, !flush: IF/ID <= {pc, imem_rdata, valid=1}; pc_en=1; the state stays REQ, giving back-to-back fetches at 1 instruction per cycle with zero-wait memory.
REQ-019 REQ, ack, id_stall, !flush: {pc, imem_rdata} goes to the skid buffer; pc_en=1; the state goes to HOLD; IF/ID is unchanged.
REQ-020 HOLD: imem_req=0 and pc_en=0.
REQ-021 HOLD, on the first cycle with !id_stall: the skid buffer moves to IF/ID with valid=1, and the state goes to REQ.
REQ-022 No new instruction and !id_stall: if_id_valid <= 0 and if_id_instr <= NOP_INSTR (bubble).
REQ-023 id_stall=1 without flush: all IF/ID fields hold.
REQ-024 flush has priority over all other inputs: if_id_valid <= 0, if_id_instr <= NOP_INSTR, the skid buffer is emptied, and pc_en=1 in every state.
REQ-025 flush in REQ without ack: drain_addr <= pc; the state goes to DRAIN.
REQ-026 flush in REQ with ack: the data is discarded; the state stays REQ.
REQ-027 flush in BOOT or HOLD: the state goes to REQ.
REQ-028 DRAIN: imem_req=1, imem_addr=drain_addr, pc_en=0 unless flush.
REQ-029 DRAIN, on ack: the data is discarded and the state goes to REQ.
REQ-030 flush in DRAIN: pc_en=1 (new target); drain_addr is unchanged.
REQ-031 Address arithmetic is unsigned `INSTR_WIDTH and the block never alters pc, so wrap-around is handled upstream.
REQ-032 The skid buffer depth is exactly one entry.

Reset
REQ-033 While rst=1: state <= BOOT, if_id_valid <= 0, if_id_pc <= 0, if_id_instr <= NOP_INSTR, skid buffer empty, drain_addr <= 0.
REQ-034 While rst=1: pc_en=0 and imem_req=0.
REQ-035 rst asserted mid-request abandons the request; the memory must accept a dropped imem_req.

Structure
REQ-036 `INSTR_WIDTH, the FSM state encodings and the default NOP value belong in the shared defines.v.
REQ-037 The one-entry skid buffer shall be a sub-module named fetch_skid_buf, with load/unload/clear ports and a full flag.
REQ-038 All outputs except pc_en, imem_req and imem_addr shall be registered.

Verification
REQ-039 Reset release with zero-wait memory (ack tied to req), no stall -> cycle 1 pc_en=1; then if_id_pc = 0, 4, 8 on consecutive cycles, valid=1.
REQ-040 Memory ack after 3 cycles -> imem_req high with addr constant for 3 cycles, pc_en=1 only in the ack cycle, one IF/ID entry per 3 cycles.
REQ-041 id_stall for 2 cycles while ack for pc=8 arrives -> IF/ID holds pc=4, state HOLD with no request; after stall drops, IF/ID = pc 8 and fetch resumes at 12.
REQ-042 flush while waiting on pc=16 (ack late) -> DRAIN keeps addr=16 until ack, data discarded, next request at the target (e.g. 0x100), if_id_valid=0 meanwhile.
REQ-043 flush coincident with ack -> data dropped, if_id_valid=0, next fetch at the target address.
REQ-044 rst asserted in HOLD -> next cycle state BOOT, if_id_valid=0, if_id_instr=NOP_INSTR, skid buffer empty.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared widths, default NOP word and FSM state encoding for the instruction fetch unit.
`timescale 1ns/1ps
package fetch_unit_pkg;

    localparam int unsigned INSTR_WIDTH = 32;
    localparam logic [INSTR_WIDTH-1:0] NOP_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer that parks a fetched {pc, instr} while decode is stalled.
`timescale 1ns/1ps
module fetch_skid_buf
    import fetch_unit_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   load,
    input  logic                   unload,
    input  logic [INSTR_WIDTH-1:0] load_pc,
    input  logic [INSTR_WIDTH-1:0] load_instr,
    output logic [INSTR_WIDTH-1:0] buf_pc,
    output logic [INSTR_WIDTH-1:0] buf_instr,
    output logic                   full
);

    logic                   full_r;
    logic [INSTR_WIDTH-1:0] pc_r;
    logic [INSTR_WIDTH-1:0] instr_r;

    // Occupancy and payload; clear (flush) wins over a simultaneous load.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_r  <= 1'b0;
            pc_r    <= {INSTR_WIDTH{1'b0}};
            instr_r <= {INSTR_WIDTH{1'b0}};
        end else if (clear) begin
            full_r  <= 1'b0;
        end else if (load) begin
            full_r  <= 1'b1;
            pc_r    <= load_pc;
            instr_r <= load_instr;
        end else if (unload) begin
            full_r  <= 1'b0;
        end else begin
            full_r  <= full_r;
        end
    end

    assign full      = full_r;
    assign buf_pc    = pc_r;
    assign buf_instr = instr_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM driving the PC enable and instruction memory, feeding the IF/ID register.
`timescale 1ns/1ps
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = NOP_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INSTR_WIDTH-1:0] pc,
    output logic                   pc_en,
    output logic                   imem_req,
    output logic [INSTR_WIDTH-1:0] imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   id_stall,
    input  logic                   flush,
    output logic [INSTR_WIDTH-1:0] if_id_pc,
    output logic [INSTR_WIDTH-1:0] if_id_instr,
    output logic                   if_id_valid
);

    fetch_state_e           state_r;
    fetch_state_e           state_s;
    logic [INSTR_WIDTH-1:0] drain_addr_r;
    logic                   take_s;
    logic                   skid_load_s;
    logic                   skid_unload_s;
    logic                   drain_load_s;
    logic                   skid_full_s;
    logic [INSTR_WIDTH-1:0] skid_pc_s;
    logic [INSTR_WIDTH-1:0] skid_instr_s;

    fetch_skid_buf u_skid (
        .clk        (clk),
        .rst        (rst),
        .clear      (flush),
        .load       (skid_load_s),
        .unload     (skid_unload_s),
        .load_pc    (pc),
        .load_instr (imem_rdata),
        .buf_pc     (skid_pc_s),
        .buf_instr  (skid_instr_s),
        .full       (skid_full_s)
    );

    // Next-state and memory/PC handshake; reset forces the handshake idle.
    always_comb begin
        state_s       = state_r;
        pc_en         = 1'b0;
        imem_req      = 1'b0;
        imem_addr     = pc;
        take_s        = 1'b0;
        skid_load_s   = 1'b0;
        skid_unload_s = 1'b0;
        drain_load_s  = 1'b0;
        if (rst) begin
            state_s = ST_BOOT;
        end else begin
            case (state_r)
                ST_BOOT: begin
                    pc_en   = 1'b1;
                    state_s = ST_REQ;
                end
                ST_REQ: begin
                    imem_req = 1'b1;
                    if (flush) begin
                        pc_en = 1'b1;
                        if (imem_ack) begin
                            state_s = ST_REQ;
                        end else begin
                            drain_load_s = 1'b1;
                            state_s      = ST_DRAIN;
                        end
                    end else if (imem_ack) begin
                        pc_en = 1'b1;
                        if (id_stall) begin
                            skid_load_s = 1'b1;
                            state_s     = ST_HOLD;
                        end else begin
                            take_s  = 1'b1;
                            state_s = ST_REQ;
                        end
                    end else begin
                        state_s = ST_REQ;
                    end
                end
                ST_HOLD: begin
                    if (flush) begin
                        pc_en   = 1'b1;
                        state_s = ST_REQ;
                    end else if (!id_stall) begin
                        skid_unload_s = skid_full_s;
                        state_s       = ST_REQ;
                    end else begin
                        state_s = ST_HOLD;
                    end
                end
                ST_DRAIN: begin
                    // The abandoned request must complete at its original address.
                    imem_req  = 1'b1;
                    imem_addr = drain_addr_r;
                    pc_en     = flush;
                    if (imem_ack) begin
                        state_s = ST_REQ;
                    end else begin
                        state_s = ST_DRAIN;
                    end
                end
                default: begin
                    state_s = ST_BOOT;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_BOOT;
        end else begin
            state_r <= state_s;
        end
    end

    // Address of the in-flight request abandoned by a flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            drain_addr_r <= {INSTR_WIDTH{1'b0}};
        end else if (drain_load_s) begin
            drain_addr_r <= pc;
        end else begin
            drain_addr_r <= drain_addr_r;
        end
    end

    // IF/ID register: flush beats everything, stall holds, otherwise new word or bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_id_valid <= 1'b0;
            if_id_pc    <= {INSTR_WIDTH{1'b0}};
            if_id_instr <= NOP_INSTR;
        end else if (flush) begin
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
        end else if (take_s) begin
            if_id_valid <= 1'b1;
            if_id_pc    <= pc;
            if_id_instr <= imem_rdata;
        end else if (skid_unload_s) begin
            if_id_valid <= 1'b1;
            if_id_pc    <= skid_pc_s;
            if_id_instr <= skid_instr_s;
        end else if (id_stall) begin
            if_id_valid <= if_id_valid;
        end else begin
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: PC register and latency-programmable memory around the DUT.
`timescale 1ns/1ps
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc;
    logic        pc_en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] target = 32'h0;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;

    int checks = 0;
    int errors = 0;
    int wait_n = 0;
    int wcnt = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    fetch_unit #(.NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_en(pc_en),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .id_stall(id_stall), .flush(flush),
        .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    // Memory: acknowledges after wait_n idle request cycles.
    assign imem_ack   = imem_req && (wcnt >= wait_n);
    assign imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    always @(posedge clk) begin
        if (!imem_req || imem_ack) wcnt <= 0;
        else                       wcnt <= wcnt + 1;
    end

    // Upstream PC register with redirect mux.
    always @(posedge clk) begin
        if (rst)        pc <= 32'hFFFF_FFFC;
        else if (pc_en) pc <= flush ? target : pc + 32'd4;
    end

    // Reference model: booting flag, parked word, discarded outstanding request, IF/ID contents.
    logic        m_boot, m_held_v, m_disc_v, m_ifid_v;
    logic [31:0] m_held_pc, m_held_instr, m_disc_addr, m_ifid_pc, m_ifid_instr;
    logic        e_pc_en, e_req;
    logic [31:0] e_addr;
    logic        fresh;

    assign fresh = !m_boot && !m_held_v && !m_disc_v && imem_ack;

    always_comb begin
        e_pc_en = 1'b0;
        e_req   = 1'b0;
        e_addr  = 32'h0;
        if (rst) begin
            e_pc_en = 1'b0;
        end else if (m_boot) begin
            e_pc_en = 1'b1;
        end else if (m_held_v) begin
            e_pc_en = flush;
        end else if (m_disc_v) begin
            e_req   = 1'b1;
            e_addr  = m_disc_addr;
            e_pc_en = flush;
        end else begin
            e_req   = 1'b1;
            e_addr  = pc;
            e_pc_en = flush | imem_ack;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            m_boot <= 1'b1; m_held_v <= 1'b0; m_disc_v <= 1'b0;
            m_ifid_v <= 1'b0; m_ifid_pc <= 32'h0; m_ifid_instr <= NOP;
        end else begin
            m_boot <= 1'b0;
            if (m_disc_v && imem_ack) m_disc_v <= 1'b0;
            if (flush) begin
                m_ifid_v <= 1'b0; m_ifid_instr <= NOP; m_held_v <= 1'b0;
                if (!m_boot && !m_held_v && !m_disc_v && !imem_ack) begin
                    m_disc_v <= 1'b1; m_disc_addr <= pc;
                end
            end else if (fresh && id_stall) begin
                m_held_v <= 1'b1; m_held_pc <= pc; m_held_instr <= imem_rdata;
            end else if (fresh) begin
                m_ifid_v <= 1'b1; m_ifid_pc <= pc; m_ifid_instr <= imem_rdata;
            end else if (m_held_v && !id_stall) begin
                m_ifid_v <= 1'b1; m_ifid_pc <= m_held_pc; m_ifid_instr <= m_held_instr;
                m_held_v <= 1'b0;
            end else if (!id_stall) begin
                m_ifid_v <= 1'b0; m_ifid_instr <= NOP;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc_en", {31'd0, pc_en}, {31'd0, e_pc_en});
            chk("imem_req", {31'd0, imem_req}, {31'd0, e_req});
            if (e_req) chk("imem_addr", imem_addr, e_addr);
            chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_ifid_v});
            chk("if_id_pc", if_id_pc, m_ifid_pc);
            chk("if_id_instr", if_id_instr, m_ifid_instr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; id_stall = 1'b0; wait_n = 0;
        tick(); tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        tick();
        chk_en = 1'b1;
        mid();
        chk("lit_rst_pc_en", {31'd0, pc_en}, 32'd0);
        chk("lit_rst_req", {31'd0, imem_req}, 32'd0);
        chk("lit_rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("lit_rst_pc", if_id_pc, 32'h0);
        chk("lit_rst_instr", if_id_instr, 32'h0000_0013);

        // Zero-wait back-to-back fetch from reset
        do_reset(); mid();
        chk("lit_boot_pc_en", {31'd0, pc_en}, 32'd1);
        chk("lit_boot_req", {31'd0, imem_req}, 32'd0);
        chk("lit_boot_pc", pc, 32'hFFFF_FFFC);
        tick(); mid();
        chk("lit_s1_addr0", imem_addr, 32'h0);
        tick(); mid();
        chk("lit_s1_ifid0", if_id_pc, 32'h0);
        chk("lit_s1_instr0", if_id_instr, 32'hC0DE_0000);
        chk("lit_s1_valid", {31'd0, if_id_valid}, 32'd1);
        tick(); mid();
        chk("lit_s1_ifid4", if_id_pc, 32'h4);
        tick(); mid();
        chk("lit_s1_ifid8", if_id_pc, 32'h8);

        // Three-cycle memory
        do_reset(); wait_n = 2; mid();
        for (int k = 0; k < 3; k++) begin
            tick(); mid();
            chk("lit_s2_addr", imem_addr, 32'h0);
            chk("lit_s2_req", {31'd0, imem_req}, 32'd1);
            chk("lit_s2_pc_en", {31'd0, pc_en}, (k == 2) ? 32'd1 : 32'd0);
        end
        tick(); mid();
        chk("lit_s2_ifid0", if_id_pc, 32'h0);
        chk("lit_s2_valid0", {31'd0, if_id_valid}, 32'd1);
        tick(); mid();
        chk("lit_s2_bubble", {31'd0, if_id_valid}, 32'd0);
        chk("lit_s2_bubble_nop", if_id_instr, 32'h0000_0013);
        tick(); tick(); mid();
        chk("lit_s2_ifid4", if_id_pc, 32'h4);
        chk("lit_s2_valid4", {31'd0, if_id_valid}, 32'd1);

        // Decode stall while pc=8 is acknowledged
        do_reset(); tick(); tick(); tick();
        id_stall = 1'b1; mid();
        chk("lit_s3_addr8", imem_addr, 32'h8);
        chk("lit_s3_pc_en", {31'd0, pc_en}, 32'd1);
        chk("lit_s3_ifid4", if_id_pc, 32'h4);
        tick(); mid();
        chk("lit_s3_hold_req", {31'd0, imem_req}, 32'd0);
        chk("lit_s3_hold_pc_en", {31'd0, pc_en}, 32'd0);
        chk("lit_s3_hold_ifid", if_id_pc, 32'h4);
        tick(); id_stall = 1'b0; mid();
        chk("lit_s3_hold2_req", {31'd0, imem_req}, 32'd0);
        chk("lit_s3_hold2_ifid", if_id_pc, 32'h4);
        tick(); mid();
        chk("lit_s3_ifid8", if_id_pc, 32'h8);
        chk("lit_s3_instr8", if_id_instr, 32'hC0DE_0008);
        chk("lit_s3_addr12", imem_addr, 32'hC);

        // Flush while a slow fetch of pc=16 is outstanding
        do_reset(); tick(); tick(); tick(); tick(); tick();
        wait_n = 3; flush = 1'b1; target = 32'h100; mid();
        chk("lit_s4_addr16", imem_addr, 32'h10);
        chk("lit_s4_pc_en", {31'd0, pc_en}, 32'd1);
        tick(); flush = 1'b0; mid();
        chk("lit_s4_drain_addr", imem_addr, 32'h10);
        chk("lit_s4_drain_pc_en", {31'd0, pc_en}, 32'd0);
        chk("lit_s4_drain_valid", {31'd0, if_id_valid}, 32'd0);
        tick(); mid();
        chk("lit_s4_drain_addr2", imem_addr, 32'h10);
        tick(); mid();
        chk("lit_s4_drain_ack_addr", imem_addr, 32'h10);
        chk("lit_s4_drain_ack_pc_en", {31'd0, pc_en}, 32'd0);
        tick(); wait_n = 0; mid();
        chk("lit_s4_target_addr", imem_addr, 32'h100);
        chk("lit_s4_target_valid", {31'd0, if_id_valid}, 32'd0);
        tick(); mid();
        chk("lit_s4_ifid_target", if_id_pc, 32'h100);
        chk("lit_s4_valid_target", {31'd0, if_id_valid}, 32'd1);

        // Flush coincident with ack
        do_reset(); tick(); tick();
        flush = 1'b1; target = 32'h200; mid();
        chk("lit_s5_addr4", imem_addr, 32'h4);
        chk("lit_s5_pc_en", {31'd0, pc_en}, 32'd1);
        tick(); flush = 1'b0; mid();
        chk("lit_s5_target_addr", imem_addr, 32'h200);
        chk("lit_s5_valid", {31'd0, if_id_valid}, 32'd0);
        chk("lit_s5_nop", if_id_instr, 32'h0000_0013);
        tick(); mid();
        chk("lit_s5_ifid", if_id_pc, 32'h200);
        chk("lit_s5_instr", if_id_instr, 32'hC0DE_0200);

        // Reset while parked in HOLD
        do_reset(); tick(); tick(); tick();
        id_stall = 1'b1;
        tick(); rst = 1'b1; mid();
        chk("lit_s6_rst_pc_en", {31'd0, pc_en}, 32'd0);
        chk("lit_s6_rst_req", {31'd0, imem_req}, 32'd0);
        tick(); rst = 1'b0; id_stall = 1'b0; mid();
        chk("lit_s6_boot_pc_en", {31'd0, pc_en}, 32'd1);
        chk("lit_s6_boot_req", {31'd0, imem_req}, 32'd0);
        chk("lit_s6_valid", {31'd0, if_id_valid}, 32'd0);
        chk("lit_s6_nop", if_id_instr, 32'h0000_0013);
        tick(); mid();
        chk("lit_s6_addr0", imem_addr, 32'h0);
        tick(); mid();
        chk("lit_s6_ifid0", if_id_pc, 32'h0);
        chk("lit_s6_valid0", {31'd0, if_id_valid}, 32'd1);

        // Mixed stall/flush/latency table, checked by the model every cycle
        do_reset();
        for (int i = 0; i < 300; i++) begin
            tick();
            id_stall = (i % 7 == 2) || (i % 7 == 3) || (i % 11 == 5);
            flush    = (i % 13 == 6);
            target   = 32'h0000_1000 + 32'(i) * 32'd16;
            wait_n   = (i / 50) % 3;
        end
        tick(); flush = 1'b0; id_stall = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
